// File: rtl/cpu_muldiv_pkg.sv
// cpu_muldiv_pkg: shared constants and enums for the iterative multiply/divide unit
package cpu_muldiv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {MUL, MULHU, DIVU, REMU} muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, WB} muldiv_state_e;
endpackage

// File: rtl/cpu_muldiv_step.sv
// cpu_muldiv_step: one shift-add (multiply) or restoring-subtract (divide) iteration
module cpu_muldiv_step #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);
  logic [W:0] w_sum, w_shl, w_dif;
  // Both candidate steps are built; the op class picks one. The divide needs a
  // 33-bit partial remainder because the shifted value can reach 2*divisor.
  always_comb begin
    w_sum = {1'b0, i_hi} + {1'b0, i_lo[0] ? i_b : '0};
    w_shl = {i_hi, i_lo[W-1]};
    w_dif = w_shl - {1'b0, i_b};
    o_hi  = i_div ? (w_dif[W] ? w_shl[W-1:0] : w_dif[W-1:0]) : w_sum[W:1];
    o_lo  = i_div ? {i_lo[W-2:0], ~w_dif[W]} : {w_sum[0], i_lo[W-1:1]};
  end
endmodule

// File: rtl/cpu_muldiv_unit.sv
// cpu_muldiv_unit: 32-iteration multiply/divide unit with one-cycle write-back; signed ops via CPU_MULDIV_SIGNED_EN
module cpu_muldiv_unit
  import cpu_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              op_signed,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_e     r_state;
  muldiv_op_e        r_op;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_b, r_wb_data;
  logic [ADDR_W-1:0] r_rd, r_wb_addr;
  logic              r_busy, r_wb_en, r_neg;
  logic [XLEN-1:0]   w_hi_n, w_lo_n, w_a_mag, w_b_mag, w_sel, w_res;
  logic [2*XLEN-1:0] w_prod;
  logic              w_sgn, w_sa, w_sb, w_div, w_div0;
`ifdef CPU_MULDIV_SIGNED_EN
  assign w_sgn = op_signed;
`else
  assign w_sgn = op_signed & 1'b0;
`endif
  // Signed ops run on magnitudes; r_neg remembers whether the result must be negated.
  assign w_sa    = w_sgn & rs1_data[XLEN-1];
  assign w_sb    = w_sgn & rs2_data[XLEN-1];
  assign w_a_mag = w_sa ? -rs1_data : rs1_data;
  assign w_b_mag = w_sb ? -rs2_data : rs2_data;
  assign w_div0  = op[1] && rs2_data == '0;
  assign w_div   = r_op == DIVU || r_op == REMU;
  assign w_prod  = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
  assign w_sel   = (r_op == MULHU || r_op == REMU) ? w_hi_n : w_lo_n;
  assign w_res   = w_div ? (r_neg ? -w_sel : w_sel)
                 : (r_op == MULHU ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);
  cpu_muldiv_step #(.W(XLEN)) u_step (
    .i_div(w_div),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .i_b  (r_b),
    .o_hi (w_hi_n),
    .o_lo (w_lo_n)
  );
  // Control FSM with datapath registers and registered write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= MUL;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_op   <= muldiv_op_e'(op);
          r_rd   <= rd_addr;
          r_hi   <= '0;
          r_lo   <= w_a_mag;
          r_b    <= w_b_mag;
          r_neg  <= w_sa ^ (w_sb & (op != REMU));
          r_cnt  <= '0;
          r_busy <= 1'b1;
          if (w_div0) begin
            r_state   <= WB;
            r_wb_en   <= 1'b1;
            r_wb_addr <= rd_addr;
            r_wb_data <= op[0] ? rs1_data : '1;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state   <= WB;
            r_wb_en   <= 1'b1;
            r_wb_addr <= r_rd;
            r_wb_data <= w_res;
          end
        end
        WB: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy    = r_busy;
  assign wb_en   = r_wb_en;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;
endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// tb_cpu_muldiv_unit: scoreboard bench for the iterative multiply/divide unit
module tb_cpu_muldiv_unit;
  import cpu_muldiv_pkg::*;
  typedef struct {logic [4:0] a; logic [31:0] d;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, op_signed = 0;
  logic [1:0] op = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0;
  logic [4:0] rd_addr = 0;
  logic busy, wb_en;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  int pass = 0, total = 0;
  exp_t sb[$];

  cpu_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_signed(op_signed),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input bit push);
    @(negedge clk);
    start = 1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    if (push) sb.push_back('{rd, model(o, a, b)});
    @(negedge clk);
    start = 0; rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
  endtask

  task automatic collect(input int lat0, output int lat, output int bc, output logic [4:0] a, output logic [31:0] d, output logic after);
    lat = lat0; bc = 0;
    while (!wb_en && lat < 100) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
    bc += int'(busy); a = wb_addr; d = wb_data;
    @(negedge clk);
    after = wb_en;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    total++; if (wb_en !== 1'b0) $display("FAIL reset_wb_en got %b want 0", wb_en); else pass++;
    total++; if (wb_addr !== 5'd0) $display("FAIL reset_wb_addr got %0d want 0", wb_addr); else pass++;
    total++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data got %h want 0", wb_data); else pass++;
    rst_n = 1;
  endtask

  task automatic test_mul();
    int lat, bc; logic [4:0] a; logic [31:0] d; logic af; exp_t e;
    drive(MUL, 7, 3, 5, 1);
    collect(1, lat, bc, a, d, af);
    e = sb.pop_front();
    total++; if (lat !== 33) $display("FAIL mul_latency got %0d want 33", lat); else pass++;
    total++; if (bc !== 33) $display("FAIL mul_busy_cycles got %0d want 33", bc); else pass++;
    total++; if (a !== e.a) $display("FAIL mul_addr got %0d want %0d", a, e.a); else pass++;
    total++; if (d !== e.d) $display("FAIL mul_data got %h want %h", d, e.d); else pass++;
    total++; if (af !== 1'b0) $display("FAIL mul_single_pulse got %b want 0", af); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL mul_busy_after got %b want 0", busy); else pass++;
  endtask

  task automatic test_arith();
    int lat, bc; logic [4:0] a; logic [31:0] d; logic af; exp_t e;
    logic [1:0]  t_op [5] = '{MULHU, MUL, DIVU, REMU, DIVU};
    logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 49, 49, 3};
    logic [31:0] t_b  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 2, 49};
    for (int i = 0; i < 5; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 5'(i + 10), 1);
      collect(1, lat, bc, a, d, af);
      e = sb.pop_front();
      total++; if (lat !== 33) $display("FAIL arith%0d_latency got %0d want 33", i, lat); else pass++;
      total++; if (a !== e.a) $display("FAIL arith%0d_addr got %0d want %0d", i, a, e.a); else pass++;
      total++; if (d !== e.d) $display("FAIL arith%0d_data got %h want %h", i, d, e.d); else pass++;
    end
  endtask

  task automatic test_divzero();
    int lat, bc; logic [4:0] a; logic [31:0] d; logic af; exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(i == 0 ? DIVU : REMU, 49, 0, 5'(i), 1);
      collect(1, lat, bc, a, d, af);
      e = sb.pop_front();
      total++; if (lat !== 1) $display("FAIL div0_%0d_latency got %0d want 1", i, lat); else pass++;
      total++; if (bc !== 1) $display("FAIL div0_%0d_busy_cycles got %0d want 1", i, bc); else pass++;
      total++; if (a !== e.a) $display("FAIL div0_%0d_addr got %0d want %0d", i, a, e.a); else pass++;
      total++; if (d !== e.d) $display("FAIL div0_%0d_data got %h want %h", i, d, e.d); else pass++;
      total++; if (af !== 1'b0) $display("FAIL div0_%0d_single_pulse got %b want 0", i, af); else pass++;
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, n; logic [4:0] a; logic [31:0] d; logic af; exp_t e;
    drive(MUL, 7, 3, 7, 1);
    repeat (9) @(negedge clk);
    start = 1; op = DIVU; rs1_data = 49; rs2_data = 7; rd_addr = 8;
    @(negedge clk);
    start = 0;
    collect(11, lat, bc, a, d, af);
    e = sb.pop_front();
    total++; if (lat !== 33) $display("FAIL ignore_latency got %0d want 33", lat); else pass++;
    total++; if (a !== e.a) $display("FAIL ignore_addr got %0d want %0d", a, e.a); else pass++;
    total++; if (d !== e.d) $display("FAIL ignore_data got %h want %h", d, e.d); else pass++;
    n = int'(af);
    repeat (40) begin @(negedge clk); n += int'(wb_en); end
    total++; if (n !== 0) $display("FAIL ignore_extra_wb got %0d want 0", n); else pass++;
  endtask

  task automatic test_reset_midcalc();
    int lat, bc, n; logic [4:0] a; logic [31:0] d; logic af; exp_t e;
    drive(MUL, 7, 3, 4, 0);
    repeat (14) @(negedge clk);
    rst_n = 0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass++;
    total++; if (wb_en !== 1'b0) $display("FAIL midrst_wb_en got %b want 0", wb_en); else pass++;
    total++; if (wb_addr !== 5'd0) $display("FAIL midrst_wb_addr got %0d want 0", wb_addr); else pass++;
    total++; if (wb_data !== 32'd0) $display("FAIL midrst_wb_data got %h want 0", wb_data); else pass++;
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (40) begin @(negedge clk); n += int'(wb_en); end
    total++; if (n !== 0) $display("FAIL midrst_no_wb got %0d want 0", n); else pass++;
    drive(MUL, 2, 3, 6, 1);
    collect(1, lat, bc, a, d, af);
    e = sb.pop_front();
    total++; if (lat !== 33) $display("FAIL midrst_new_latency got %0d want 33", lat); else pass++;
    total++; if (a !== e.a) $display("FAIL midrst_new_addr got %0d want %0d", a, e.a); else pass++;
    total++; if (d !== e.d) $display("FAIL midrst_new_data got %h want %h", d, e.d); else pass++;
  endtask

  task automatic test_random();
    int lat, bc, want; logic [4:0] a; logic [31:0] d, x, y; logic af; logic [1:0] o; exp_t e;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 5) ? 32'd0 : (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      want = (o[1] && y == 0) ? 1 : 33;
      drive(o, x, y, 5'($urandom), 1);
      collect(1, lat, bc, a, d, af);
      e = sb.pop_front();
      total++; if (lat !== want) $display("FAIL rand%0d_latency got %0d want %0d", i, lat, want); else pass++;
      total++; if (a !== e.a) $display("FAIL rand%0d_addr got %0d want %0d", i, a, e.a); else pass++;
      total++; if (d !== e.d) $display("FAIL rand%0d_data op %0d a %h b %h got %h want %h", i, o, x, y, d, e.d); else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_arith();
    test_divzero();
    test_back_to_back();
    test_reset_midcalc();
    test_random();
    total++; if (sb.size() !== 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
